ps2_scancode_sequencer: RTL and testbench

//  Sits behind the PS/2 byte receiver (clk domain) and turns its raw scan-code byte stream into key events.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_if.sv | 28 ++
 rtl/ps2_event_fifo.sv | 48 ++++
 rtl/ps2_scancode_sequencer.sv | 159 +++++++++++++++
 tb/tb_ps2_scancode_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Scan-code constants, sequencer FSM states and the queued key-event type
// shared by the PS/2 scan-code sequencer and its event FIFO.
package ps2_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  // Pause/Break sends E1 followed by seven more bytes that carry no key event
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PE0,
    ST_PF0,
    ST_PE0F0,
    ST_PAUSE
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

endpackage

// File: rtl/ps2_if.sv
// Byte-receiver input, key-event output and status bundle of the PS/2 sequencer.
// master = receiver/consumer side, slave = the sequencer.
interface ps2_if #(
  parameter int ERR_W = 8
);
  logic [7:0]       rx_byte;
  logic             rx_valid;
  logic             rx_err;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             key_brk;
  logic             key_valid;
  logic             key_ready;
  logic             shift_held;
  logic             ovf;
  logic             ovf_clr;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output rx_byte, rx_valid, rx_err, key_ready, ovf_clr,
    input  key_code, key_ext, key_brk, key_valid, shift_held, ovf, err_cnt
  );

  modport slave (
    input  rx_byte, rx_valid, rx_err, key_ready, ovf_clr,
    output key_code, key_ext, key_brk, key_valid, shift_held, ovf, err_cnt
  );
endinterface

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through key-event FIFO; a push into a full FIFO only lands
// when a pop frees the head in the same cycle.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  key_event_t                 din,
  input  logic                       pop,
  output key_event_t                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  key_event_t      mem [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [AW:0]     cnt;
  logic            do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = cnt;
  // Storage is not reset, so mask the head while empty
  assign dout    = empty ? '0 : mem[rp];

  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/ps2_scancode_sequencer.sv
// Turns PS/2 receiver bytes into {ext,brk,code} key events queued in a FWFT FIFO.
// Optional auto-repeat suppression: define PS2_TYPEMATIC_FILTER_EN.
module ps2_scancode_sequencer
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int ERR_W          = 8
) (
  input logic   clk,
  input logic   reset,
  ps2_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_e      state_q, state_d;
  logic [2:0]      pcnt_q, pcnt_d;
  logic [TW-1:0]   tcnt_q;
  logic            tmo, emit, suppress, emit_q;
  key_event_t      ev, ev_q, head;
  logic            lsh_q, rsh_q, ovf_q;
  logic [ERR_W-1:0] err_q;
  logic            fifo_full, fifo_empty, pop, drop;
  logic [AW:0]     fifo_cnt;

  assign tmo = (state_q != ST_IDLE) && (tcnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    emit    = 1'b0;
    ev      = '0;
    ev.code = bus.rx_byte;
    if (bus.rx_err) begin
      state_d = ST_IDLE;
    end else if (bus.rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.rx_byte == SC_E0)      state_d = ST_PE0;
          else if (bus.rx_byte == SC_F0) state_d = ST_PF0;
          else if (bus.rx_byte == SC_E1) begin
            state_d = ST_PAUSE;
            pcnt_d  = PAUSE_TAIL;
          end else emit = 1'b1;
        end
        ST_PE0: begin
          if (bus.rx_byte == SC_F0) state_d = ST_PE0F0;
          else if (bus.rx_byte != SC_E0) begin
            emit    = 1'b1;
            ev.ext  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_PF0: begin
          emit    = 1'b1;
          ev.brk  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_PE0F0: begin
          emit    = 1'b1;
          ev.ext  = 1'b1;
          ev.brk  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_PAUSE: begin
          pcnt_d = pcnt_q - 3'd1;
          if (pcnt_q == 3'd1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      if (state_q == ST_IDLE || bus.rx_valid || bus.rx_err || tmo) tcnt_q <= '0;
      else tcnt_q <= tcnt_q + 1'b1;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       lm_vld;
  logic [8:0] lm;

  // A repeated make of the key still held is the keyboard's auto-repeat
  assign suppress = emit && !ev.brk && lm_vld && (lm == {ev.ext, ev.code});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lm_vld <= 1'b0;
      lm     <= '0;
    end else if (bus.rx_err) begin
      lm_vld <= 1'b0;
    end else if (emit) begin
      if (!ev.brk) begin
        lm_vld <= 1'b1;
        lm     <= {ev.ext, ev.code};
      end else if (lm_vld && lm == {ev.ext, ev.code}) begin
        lm_vld <= 1'b0;
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign pop  = bus.key_ready & ~fifo_empty;
  assign drop = emit_q & fifo_full & ~pop;

  // Shift state follows every emitted event, whether or not the FIFO keeps it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      emit_q <= 1'b0;
      ev_q   <= '0;
      lsh_q  <= 1'b0;
      rsh_q  <= 1'b0;
      err_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      emit_q <= emit & ~suppress;
      if (emit) ev_q <= ev;
      if (emit && !ev.ext && ev.code == SC_LSHIFT) lsh_q <= ~ev.brk;
      if (emit && !ev.ext && ev.code == SC_RSHIFT) rsh_q <= ~ev.brk;
      if (bus.rx_err && err_q != '1) err_q <= err_q + 1'b1;
      if (drop)             ovf_q <= 1'b1;
      else if (bus.ovf_clr) ovf_q <= 1'b0;
    end
  end

  ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (emit_q),
    .din   (ev_q),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign bus.key_code   = head.code;
  assign bus.key_ext    = head.ext;
  assign bus.key_brk    = head.brk;
  assign bus.key_valid  = (fifo_cnt != '0);
  assign bus.shift_held = lsh_q | rsh_q;
  assign bus.ovf        = ovf_q;
  assign bus.err_cnt    = err_q;
endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// Directed bench for the PS/2 scan-code sequencer: prefixes, pause, FIFO
// full/overflow, timeout, receiver errors, shift tracking and async reset.
module tb_ps2_scancode_sequencer;
  import ps2_pkg::*;

  localparam int DEPTH = 8;
  localparam int TMO   = 20;
  localparam int EW    = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ps2_if #(.ERR_W(EW)) bus ();

  ps2_scancode_sequencer #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO),
    .ERR_W          (EW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop1;
    bus.key_ready = 1'b1;
    @(negedge clk);
    bus.key_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code, bus.shift_held, bus.ovf, bus.err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b e=%b b=%b c=%h sh=%b ovf=%b err=%h exp all 0",
               bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code, bus.shift_held, bus.ovf, bus.err_cnt);
    end
  endtask

  task automatic test_make;
    send(8'h1C);
    checks++;
    if (bus.key_valid !== 1'b0) begin
      errors++; $display("FAIL make_early key_valid got %b exp 0", bus.key_valid);
    end
    idle(1);
    checks++;
    if ({bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code} !== {1'b1, 10'h01C}) begin
      errors++; $display("FAIL make_head got %h exp %h", {bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code}, {1'b1, 10'h01C});
    end
    pop1();
    checks++;
    if (bus.key_valid !== 1'b0) begin
      errors++; $display("FAIL make_pop key_valid got %b exp 0", bus.key_valid);
    end
    // ready already high while the FIFO is empty must not eat the new event
    bus.key_ready = 1'b1;
    send(8'h1D);
    idle(1);
    bus.key_ready = 1'b0;
    checks++;
    if ({bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code} !== {1'b1, 10'h01D}) begin
      errors++; $display("FAIL empty_push_ready got %h exp %h", {bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code}, {1'b1, 10'h01D});
    end
    pop1();
  endtask

  task automatic test_prefix;
    logic [9:0] exp [3] = '{10'h11C, 10'h375, 10'h26B};
    send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'hE0); send(8'h6B);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code} !== {1'b1, exp[i]}) begin
        errors++; $display("FAIL prefix_head[%0d] got %h exp %h", i, {bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code}, {1'b1, exp[i]});
      end
      pop1();
    end
    checks++;
    if (bus.key_valid !== 1'b0) begin
      errors++; $display("FAIL prefix_drain key_valid got %b exp 0", bus.key_valid);
    end
  endtask

  task automatic test_pause;
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send(seq[i]);
    idle(2);
    checks++;
    if (bus.key_valid !== 1'b0) begin
      errors++; $display("FAIL pause_no_event key_valid got %b exp 0", bus.key_valid);
    end
    send(8'h1C);
    idle(1);
    checks++;
    if ({bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code} !== {1'b1, 10'h01C}) begin
      errors++; $display("FAIL pause_after got %h exp %h", {bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code}, {1'b1, 10'h01C});
    end
    pop1();
  endtask

  task automatic test_overflow;
    for (int i = 0; i < DEPTH; i++) send(8'h15 + 8'(i));
    idle(2);
    checks++;
    if (bus.ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_at_full got %b exp 0", bus.ovf);
    end
    send(8'h15 + 8'(DEPTH));
    idle(2);
    checks++;
    if (bus.ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_set got %b exp 1", bus.ovf);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if ({bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code} !== {3'b100, 8'h15 + 8'(i)}) begin
        errors++; $display("FAIL ovf_order[%0d] got %h exp %h", i, {bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code}, {3'b100, 8'h15 + 8'(i)});
      end
      pop1();
    end
    checks++;
    if (bus.key_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_drain key_valid got %b exp 0", bus.key_valid);
    end
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    checks++;
    if (bus.ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_clr got %b exp 0", bus.ovf);
    end
  endtask

  task automatic test_full_push_pop;
    for (int i = 0; i < DEPTH; i++) send(8'h21 + 8'(i));
    idle(1);
    @(negedge clk);
    bus.rx_byte  = 8'h21 + 8'(DEPTH);
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid  = 1'b0;
    bus.key_ready = 1'b1;
    @(negedge clk);
    bus.key_ready = 1'b0;
    checks++;
    if (bus.ovf !== 1'b0) begin
      errors++; $display("FAIL full_push_pop ovf got %b exp 0", bus.ovf);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++;
      if ({bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code} !== {3'b100, 8'h21 + 8'(i)}) begin
        errors++; $display("FAIL full_push_pop[%0d] got %h exp %h", i, {bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code}, {3'b100, 8'h21 + 8'(i)});
      end
      pop1();
    end
    checks++;
    if (bus.key_valid !== 1'b0) begin
      errors++; $display("FAIL full_push_pop_drain key_valid got %b exp 0", bus.key_valid);
    end
  endtask

  task automatic test_timeout_err;
    send(8'hF0);
    idle(TMO + 5);
    send(8'h1C);
    idle(1);
    checks++;
    if ({bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code} !== {1'b1, 10'h01C}) begin
      errors++; $display("FAIL timeout_make got %h exp %h", {bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code}, {1'b1, 10'h01C});
    end
    pop1();
    send(8'hF0);
    idle(TMO - 8);
    send(8'h1C);
    idle(1);
    checks++;
    if ({bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code} !== {1'b1, 10'h11C}) begin
      errors++; $display("FAIL before_timeout got %h exp %h", {bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code}, {1'b1, 10'h11C});
    end
    pop1();
    send(8'hE0);
    @(negedge clk);
    bus.rx_err = 1'b1;
    @(negedge clk);
    bus.rx_err = 1'b0;
    idle(1);
    checks++;
    if ({bus.key_valid, bus.err_cnt} !== {1'b0, 8'd1}) begin
      errors++; $display("FAIL err_in_pe0 got v=%b err=%0d exp v=0 err=1", bus.key_valid, bus.err_cnt);
    end
    send(8'h1C);
    idle(1);
    checks++;
    if ({bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code} !== {1'b1, 10'h01C}) begin
      errors++; $display("FAIL err_prefix_dropped got %h exp %h", {bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code}, {1'b1, 10'h01C});
    end
    pop1();
    @(negedge clk);
    bus.rx_byte  = 8'h1D;
    bus.rx_valid = 1'b1;
    bus.rx_err   = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_err   = 1'b0;
    idle(2);
    checks++;
    if ({bus.key_valid, bus.err_cnt} !== {1'b0, 8'd2}) begin
      errors++; $display("FAIL err_wins got v=%b err=%0d exp v=0 err=2", bus.key_valid, bus.err_cnt);
    end
  endtask

  task automatic test_shift;
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [9:0] exp [3] = '{10'h012, 10'h112, 10'h000};
    int n = 2;
`else
    logic [9:0] exp [3] = '{10'h012, 10'h012, 10'h112};
    int n = 3;
`endif
    send(8'h12);
    idle(1);
    checks++;
    if (bus.shift_held !== 1'b1) begin
      errors++; $display("FAIL shift_make got %b exp 1", bus.shift_held);
    end
    send(8'h12); send(8'hF0); send(8'h12);
    idle(2);
    checks++;
    if (bus.shift_held !== 1'b0) begin
      errors++; $display("FAIL shift_release got %b exp 0", bus.shift_held);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code} !== {1'b1, exp[i]}) begin
        errors++; $display("FAIL shift_event[%0d] got %h exp %h", i, {bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code}, {1'b1, exp[i]});
      end
      pop1();
    end
    checks++;
    if (bus.key_valid !== 1'b0) begin
      errors++; $display("FAIL shift_event_count key_valid got %b exp 0", bus.key_valid);
    end
    send(8'hE0); send(8'h59);
    idle(1);
    checks++;
    if ({bus.shift_held, bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code} !== {2'b01, 10'h259}) begin
      errors++; $display("FAIL ext_59_not_shift got %h exp %h", {bus.shift_held, bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code}, {2'b01, 10'h259});
    end
    pop1();
  endtask

  task automatic test_err_sat;
    bus.rx_err = 1'b1;
    repeat (260) @(negedge clk);
    bus.rx_err = 1'b0;
    checks++;
    if (bus.err_cnt !== 8'hFF) begin
      errors++; $display("FAIL err_saturate got %h exp ff", bus.err_cnt);
    end
  endtask

  task automatic test_reset_mid;
    send(8'h1C);
    send(8'hE0);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.key_valid, bus.err_cnt, bus.ovf} !== '0) begin
      errors++; $display("FAIL reset_mid got v=%b err=%h ovf=%b exp 0", bus.key_valid, bus.err_cnt, bus.ovf);
    end
    reset = 1'b1;
    send(8'h75);
    idle(1);
    checks++;
    if ({bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code} !== {1'b1, 10'h075}) begin
      errors++; $display("FAIL reset_prefix_lost got %h exp %h", {bus.key_valid, bus.key_ext, bus.key_brk, bus.key_code}, {1'b1, 10'h075});
    end
    pop1();
  endtask

  initial begin
    bus.rx_byte   = '0;
    bus.rx_valid  = 1'b0;
    bus.rx_err    = 1'b0;
    bus.key_ready = 1'b0;
    bus.ovf_clr   = 1'b0;
    idle(3);
    test_reset();
    reset = 1'b1;
    idle(1);
    test_make();
    test_prefix();
    test_pause();
    test_overflow();
    test_full_push_pop();
    test_timeout_err();
    test_shift();
    test_err_sat();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end
endmodule
